frame_decapsulation_module: RTL and testbench
=============================================

# frame_decapsulation_module

Receive-side counterpart of the TSMP encapsulation path in the HCP. Accepts TSMP frames from the controller as a 9-bit byte stream, checks the 16-byte TSMP header (destination MAC, EtherType 0xFF01, subtype, reserved byte) and strips it. Forwards the inner payload with regenerated start/end flags and the frame's subtype. Drops malformed or foreign frames and counts received and dropped frames.

## Interface
Parameters:
- GAP_TIMEOUT, 16: consecutive idle cycles (i_data_wr low) inside a frame that abort it; legal range 2..255.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- iv_local_mac  input  48  this NIC's MAC; quasi-static.
- iv_data  input  9  byte stream. Bit 8 = 1 on the first byte and on the last byte of a frame; bits 7:0 = data.
- i_data_wr  input  1  iv_data valid.
- ov_data  output  9  payload stream. Bit 8 = 1 on the first and last payload byte.
- o_data_wr  output  1  ov_data valid.
- ov_subtype  output  8  subtype of the frame being forwarded; held until the next accepted header.
- o_abort  output  1  one-cycle pulse when a forwarded frame is truncated.
- ov_rx_frame_cnt  output  16  frames fully forwarded; wraps at 0xFFFF→0.
- ov_drop_frame_cnt  output  16  frames dropped or aborted; wraps.

## Operation
- Header byte index h = 0..15:
  - h = 0..5: DMAC.
  - h = 6..11: SMAC, ignored.
  - h = 12..13: EtherType.
  - h = 14: subtype.
  - h = 15: reserved, ignored.
- Payload starts at h = 16. The minimum accepted frame is 18 bytes (payload ≥ 2 bytes), so the first and last payload flags never coincide.
- The frame is accepted when all of these hold:
  - DMAC == iv_local_mac, or DMAC == 48'hFFFF_FFFF_FFFF.
  - EtherType == 16'hFF01.
  - No end flag at h ≤ 16.
- States:
  - IDLE_S: a write with bit 8 = 1 captures byte 0 → HEAD_S. A write with bit 8 = 0 is ignored.
  - HEAD_S: shift the header bytes in and compare DMAC/EtherType on the fly. On byte 15:
    - if DMAC or EtherType failed: drop count +1 → DISCARD_S;
    - otherwise latch the subtype into a shadow register → PAYLOAD_S.
    - An end flag at h ≤ 15 means a runt: drop count +1 → IDLE_S.
  - PAYLOAD_S:
    - First payload byte: emit {1'b1, data} and load ov_subtype from the shadow register.
    - Middle bytes: emit {1'b0, data}.
    - A byte with bit 8 = 1: emit {1'b1, data}, rx count +1 → IDLE_S.
    - End flag on the first payload byte (h = 16): nothing is emitted, drop count +1 → IDLE_S.
  - DISCARD_S: consume bytes with nothing emitted; end flag → IDLE_S.
- Gap counter:
  - Counts consecutive i_data_wr = 0 cycles in HEAD_S, PAYLOAD_S and DISCARD_S; cleared by any write.
  - When it reaches GAP_TIMEOUT:
    - HEAD_S: drop count +1 → IDLE_S.
    - PAYLOAD_S, first byte not yet emitted: drop count +1 → IDLE_S.
    - PAYLOAD_S, first byte already emitted: emit {1'b1, 8'h00} with o_data_wr = 1, pulse o_abort, drop count +1 → IDLE_S.
    - DISCARD_S: → IDLE_S with no further count (already counted).
- Gaps shorter than GAP_TIMEOUT are legal anywhere. Output bytes simply follow input bytes.
- A header that fails is counted exactly once.

## Timing
- Reset values: all outputs and counters 0; state IDLE_S; gap counter 0.
- Payload byte accepted at cycle t appears on ov_data/o_data_wr at t+1 (one register stage). There is no backpressure.
- ov_subtype changes in the same cycle as the first payload byte's output and is stable through that frame's last byte.
- Counter increments are visible the cycle after the deciding input byte or timeout cycle.
- o_data_wr = 0 whenever no byte is emitted. ov_data retains its last value.
- If i_rst asserts mid-frame, the output stops immediately with no end marker. After release the block is in IDLE_S and resynchronises on the next bit-8 byte.
- The end flag and timeout cannot coincide, because a write clears the gap counter.

## Test plan
- Good frame: DMAC = iv_local_mac = 48'h00_11_22_33_44_55, EtherType FF01, subtype 8'h05, 4-byte payload A1 A2 A3 A4 → outputs 1A1, 0A2, 0A3, 1A4 on consecutive cycles starting 17 cycles after the start byte; ov_subtype = 05; rx = 1.
- Broadcast DMAC with a 2-byte payload → forwarded (1xx, 1yy); a DMAC mismatch or EtherType 0x0800 → no o_data_wr, drop = 1, and a following good frame is forwarded normally.
- Runts:
  - a 10-byte frame (end at h = 9) → drop +1, nothing emitted;
  - a 17-byte frame (end at h = 16) → drop +1, nothing emitted.
- Payload gap of GAP_TIMEOUT−1 cycles → frame forwarded intact. A gap of GAP_TIMEOUT after 3 payload bytes → marker 9'h100 and a one-cycle o_abort; drop +1, rx unchanged.
- Back-to-back frames with no idle cycle, plus rx counter preloaded by sending 65536 frames (or a forced value) → wrap to 0. Reset asserted mid-payload → all outputs 0, the next frame is parsed correctly.

Source files
------------

// File: rtl/frame_decapsulation_module.sv
`default_nettype none
// frame_decapsulation_module: validates and strips the 16-byte TSMP header, forwards the
// payload with regenerated first/last flags, and counts received and dropped frames.
// Revision: 1.0
module frame_decapsulation_module #(
  parameter int GAP_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] iv_local_mac,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  output logic [8:0]  ov_data,
  output logic        o_data_wr,
  output logic [7:0]  ov_subtype,
  output logic        o_abort,
  output logic [15:0] ov_rx_frame_cnt,
  output logic [15:0] ov_drop_frame_cnt
);

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    HEAD_S    = 2'd1,
    PAYLOAD_S = 2'd2,
    DISCARD_S = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_TIMEOUT - 1);

  state_t     state;
  logic [3:0] hcnt;
  logic [7:0] gap_cnt;
  logic       local_ok;
  logic       bcast_ok;
  logic       type_ok;
  logic [7:0] subtype_shadow;
  logic       first_sent;

  logic [7:0] byte_in;
  logic       is_end;
  logic [3:0] mac_idx;
  logic [7:0] mac_byte;
  logic       header_ok;
  logic       timeout;

  assign byte_in   = iv_data[7:0];
  assign is_end    = iv_data[8];
  assign mac_idx   = (state == IDLE_S) ? 4'd0 : hcnt;
  assign header_ok = (local_ok | bcast_ok) & type_ok;
  assign timeout   = !i_data_wr && (gap_cnt == GAP_LAST);

  // Local MAC byte expected at the current header position (byte 0 is sampled in IDLE_S).
  always_comb begin
    mac_byte = 8'h00;
    case (mac_idx)
      4'd0:    mac_byte = iv_local_mac[47:40];
      4'd1:    mac_byte = iv_local_mac[39:32];
      4'd2:    mac_byte = iv_local_mac[31:24];
      4'd3:    mac_byte = iv_local_mac[23:16];
      4'd4:    mac_byte = iv_local_mac[15:8];
      4'd5:    mac_byte = iv_local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE_S;
      hcnt              <= 4'd0;
      gap_cnt           <= 8'd0;
      local_ok          <= 1'b0;
      bcast_ok          <= 1'b0;
      type_ok           <= 1'b0;
      subtype_shadow    <= 8'h00;
      first_sent        <= 1'b0;
      ov_data           <= 9'h000;
      o_data_wr         <= 1'b0;
      ov_subtype        <= 8'h00;
      o_abort           <= 1'b0;
      ov_rx_frame_cnt   <= 16'h0000;
      ov_drop_frame_cnt <= 16'h0000;
    end else begin
      o_data_wr <= 1'b0;
      o_abort   <= 1'b0;
      if (state != IDLE_S) begin
        gap_cnt <= i_data_wr ? 8'd0 : gap_cnt + 8'd1;
      end

      case (state)
        IDLE_S: begin
          gap_cnt <= 8'd0;
          if (i_data_wr && is_end) begin
            local_ok <= (byte_in == mac_byte);
            bcast_ok <= (byte_in == 8'hFF);
            type_ok  <= 1'b1;
            hcnt     <= 4'd1;
            state    <= HEAD_S;
          end
        end

        HEAD_S: begin
          if (i_data_wr) begin
            if (is_end) begin
              ov_drop_frame_cnt <= ov_drop_frame_cnt + 16'd1;
              state             <= IDLE_S;
            end else begin
              hcnt <= hcnt + 4'd1;
              if (hcnt <= 4'd5) begin
                local_ok <= local_ok & (byte_in == mac_byte);
                bcast_ok <= bcast_ok & (byte_in == 8'hFF);
              end
              if (hcnt == 4'd12) type_ok <= type_ok & (byte_in == 8'hFF);
              if (hcnt == 4'd13) type_ok <= type_ok & (byte_in == 8'h01);
              if (hcnt == 4'd14) subtype_shadow <= byte_in;
              if (hcnt == 4'd15) begin
                if (header_ok) begin
                  first_sent <= 1'b0;
                  state      <= PAYLOAD_S;
                end else begin
                  ov_drop_frame_cnt <= ov_drop_frame_cnt + 16'd1;
                  state             <= DISCARD_S;
                end
              end
            end
          end else if (timeout) begin
            ov_drop_frame_cnt <= ov_drop_frame_cnt + 16'd1;
            state             <= IDLE_S;
          end
        end

        PAYLOAD_S: begin
          if (i_data_wr) begin
            if (!first_sent) begin
              if (is_end) begin
                ov_drop_frame_cnt <= ov_drop_frame_cnt + 16'd1;
                state             <= IDLE_S;
              end else begin
                ov_data    <= {1'b1, byte_in};
                o_data_wr  <= 1'b1;
                ov_subtype <= subtype_shadow;
                first_sent <= 1'b1;
              end
            end else begin
              ov_data   <= {is_end, byte_in};
              o_data_wr <= 1'b1;
              if (is_end) begin
                ov_rx_frame_cnt <= ov_rx_frame_cnt + 16'd1;
                state           <= IDLE_S;
              end
            end
          end else if (timeout) begin
            // A frame already started downstream must be closed with an end marker.
            if (first_sent) begin
              ov_data   <= 9'h100;
              o_data_wr <= 1'b1;
              o_abort   <= 1'b1;
            end
            ov_drop_frame_cnt <= ov_drop_frame_cnt + 16'd1;
            state             <= IDLE_S;
          end
        end

        DISCARD_S: begin
          if ((i_data_wr && is_end) || timeout) begin
            state <= IDLE_S;
          end
        end

        default: state <= IDLE_S;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_decapsulation_module.sv
`default_nettype none
// Scoreboard bench for frame_decapsulation_module: directed TSMP frames, expected payload
// bytes queued at drive time and matched (data, abort, subtype, cycle) by an output monitor.
module tb_frame_decapsulation_module;

  localparam int          GAP = 16;
  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  din = 9'h000;
  logic        wr = 1'b0;
  logic [8:0]  ov_data;
  logic        o_data_wr;
  logic [7:0]  ov_subtype;
  logic        o_abort;
  logic [15:0] ov_rx_frame_cnt;
  logic [15:0] ov_drop_frame_cnt;

  frame_decapsulation_module #(.GAP_TIMEOUT(GAP)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .iv_local_mac      (MAC),
    .iv_data           (din),
    .i_data_wr         (wr),
    .ov_data           (ov_data),
    .o_data_wr         (o_data_wr),
    .ov_subtype        (ov_subtype),
    .o_abort           (o_abort),
    .ov_rx_frame_cnt   (ov_rx_frame_cnt),
    .ov_drop_frame_cnt (ov_drop_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       abort;
    logic [7:0] st;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  pl [0:15];
  logic [15:0] exp_rx = 16'h0000;
  logic [15:0] exp_drop = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Output monitor: every emitted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (o_data_wr === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got data %h abort %b at cycle %0d, required no output",
                 ov_data, o_abort, cyc);
      end else begin
        e = sb.pop_front();
        if (ov_data !== e.data || o_abort !== e.abort || ov_subtype !== e.st || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out_byte: got data %h abort %b subtype %h cycle %0d, required data %h abort %b subtype %h cycle %0d",
                   ov_data, o_abort, ov_subtype, cyc, e.data, e.abort, e.st, e.cyc);
        end
      end
    end else if (o_abort === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL abort_alone: got o_abort 1 with o_data_wr 0, required 0");
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr = 1'b0;
    end
  endtask

  task automatic set_pl(input logic [7:0] base);
    for (int i = 0; i < 16; i++) pl[i] = base + 8'(i);
  endtask

  // Sends a frame of 16+plen bytes; optional gap after byte gap_after; stop_after>=0 truncates.
  task automatic send_frame(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] st,
                            input int plen, input bit fwd, input int gap_after, input int gap_len,
                            input int stop_after);
    int         total;
    logic [7:0] hdr [0:15];
    logic [7:0] b;
    logic       flag;
    total = 16 + plen;
    for (int i = 0; i < 6; i++) hdr[i] = dmac[8*(5-i) +: 8];
    for (int i = 6; i < 12; i++) hdr[i] = 8'hA0 + 8'(i);
    hdr[12] = et[15:8];
    hdr[13] = et[7:0];
    hdr[14] = st;
    hdr[15] = 8'h00;
    for (int i = 0; i < total; i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      b = (i < 16) ? hdr[i] : pl[i-16];
      @(negedge clk);
      din = {(i == 0) || (i == total - 1), b};
      wr  = 1'b1;
      if (fwd && i >= 16) begin
        flag = (i == 16) || (i == total - 1);
        sb.push_back('{{flag, b}, 1'b0, st, cyc + 1});
      end
      if (i == gap_after) idle(gap_len);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rx"}, 32'(ov_rx_frame_cnt), 32'(exp_rx));
    check({tag, "_drop"}, 32'(ov_drop_frame_cnt), 32'(exp_drop));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", 32'(ov_data), 32'h0);
    check("reset_wr", 32'(o_data_wr), 32'h0);
    check("reset_subtype", 32'(ov_subtype), 32'h0);
    check("reset_abort", 32'(o_abort), 32'h0);
    check_counts("reset");
    rst = 1'b0;
    idle(2);

    // Good frame, local MAC
    set_pl(8'hA1);
    send_frame(MAC, 16'hFF01, 8'h05, 4, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'd1;
    check_counts("good");
    check("good_subtype", 32'(ov_subtype), 32'h05);

    // Broadcast, minimum payload
    set_pl(8'hB1);
    send_frame(BCAST, 16'hFF01, 8'h07, 2, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'd2;
    check_counts("bcast");
    check("bcast_subtype", 32'(ov_subtype), 32'h07);

    // DMAC mismatch and wrong EtherType are dropped, subtype held
    send_frame(MAC + 48'd1, 16'hFF01, 8'h09, 4, 1'b0, -1, 0, -1);
    idle(3);
    exp_drop = 16'd1;
    check_counts("dmac_bad");
    check("dmac_bad_subtype", 32'(ov_subtype), 32'h07);
    send_frame(MAC, 16'h0800, 8'h0A, 4, 1'b0, -1, 0, -1);
    idle(3);
    exp_drop = 16'd2;
    check_counts("etype_bad");
    check("etype_bad_subtype", 32'(ov_subtype), 32'h07);

    set_pl(8'h31);
    send_frame(MAC, 16'hFF01, 8'h0B, 3, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'd3;
    check_counts("after_drop");

    // Runts: end at h=9 and at h=16
    send_frame(MAC, 16'hFF01, 8'h0B, -6, 1'b0, -1, 0, -1);
    idle(3);
    exp_drop = 16'd3;
    check_counts("runt10");
    send_frame(MAC, 16'hFF01, 8'h0C, 1, 1'b0, -1, 0, -1);
    idle(3);
    exp_drop = 16'd4;
    check_counts("runt17");
    check("runt17_subtype", 32'(ov_subtype), 32'h0B);

    // Longest legal payload gap
    set_pl(8'hC1);
    send_frame(MAC, 16'hFF01, 8'h0D, 5, 1'b1, 17, GAP - 1, -1);
    idle(3);
    exp_rx = 16'd4;
    check_counts("gap_ok");

    // Timeout after 3 payload bytes closes the frame with an abort marker
    set_pl(8'hD1);
    send_frame(MAC, 16'hFF01, 8'h0E, 10, 1'b1, -1, 0, 19);
    sb.push_back('{9'h100, 1'b1, 8'h0E, cyc + GAP + 1});
    idle(GAP + 2);
    exp_drop = 16'd5;
    check_counts("abort");

    // Timeout inside the header
    send_frame(MAC, 16'hFF01, 8'h0F, 4, 1'b0, -1, 0, 8);
    idle(GAP + 2);
    exp_drop = 16'd6;
    check_counts("head_timeout");

    // Back-to-back frames
    set_pl(8'hE1);
    send_frame(MAC, 16'hFF01, 8'h10, 2, 1'b1, -1, 0, -1);
    send_frame(MAC, 16'hFF01, 8'h11, 3, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'd6;
    check_counts("b2b");
    check("b2b_subtype", 32'(ov_subtype), 32'h11);

    // rx counter wrap from a preloaded value
    #1 force dut.ov_rx_frame_cnt = 16'hFFFF;
    #1 release dut.ov_rx_frame_cnt;
    set_pl(8'h51);
    send_frame(MAC, 16'hFF01, 8'h12, 2, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'h0000;
    check_counts("wrap");

    // Reset mid-payload
    set_pl(8'h61);
    send_frame(MAC, 16'hFF01, 8'h13, 6, 1'b1, -1, 0, 18);
    @(negedge clk);
    wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_rx   = 16'd0;
    exp_drop = 16'd0;
    check("midrst_wr", 32'(o_data_wr), 32'h0);
    check("midrst_data", 32'(ov_data), 32'h0);
    check("midrst_subtype", 32'(ov_subtype), 32'h0);
    check_counts("midrst");
    check("midrst_sb_empty", 32'(sb.size()), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    set_pl(8'h71);
    send_frame(MAC, 16'hFF01, 8'h14, 2, 1'b1, -1, 0, -1);
    idle(3);
    exp_rx = 16'd1;
    check_counts("post_rst");
    check("post_rst_subtype", 32'(ov_subtype), 32'h14);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
